// File: rtl/lcd_char_controller.sv
// HD44780 4-bit character-LCD controller: self-running power-up/init sequence, then
// queued char/home/clear/goto commands over valid/ready with cursor tracking and row wrap.
module lcd_char_controller #(
    parameter int unsigned CLK_MHZ  = 50,
    parameter int unsigned POWER_US = 130000,
    parameter int unsigned WAKE_US  = 4100,
    parameter int unsigned PULSE_US = 1,
    parameter int unsigned CMD_US   = 50,
    parameter int unsigned CLEAR_US = 1640,
    parameter int unsigned ROWS     = 2,
    parameter int unsigned COLS     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic [1:0] cur_row,
    output logic [5:0] cur_col,
    output logic       db4,
    output logic       db5,
    output logic       db6,
    output logic       db7,
    output logic       rs,
    output logic       enable,
    output logic       rw,
    output logic       lcd_power,
    output logic       lcd_bckgnd
);

    localparam int unsigned DW = $clog2(CLK_MHZ * POWER_US) + 1;

    localparam int unsigned PWR_N   = (CLK_MHZ * POWER_US > 0) ? CLK_MHZ * POWER_US : 1;
    localparam int unsigned WAKE_N  = (CLK_MHZ * WAKE_US  > 0) ? CLK_MHZ * WAKE_US  : 1;
    localparam int unsigned PULSE_N = (CLK_MHZ * PULSE_US > 0) ? CLK_MHZ * PULSE_US : 1;
    localparam int unsigned CMD_N   = (CLK_MHZ * CMD_US   > 0) ? CLK_MHZ * CMD_US   : 1;
    localparam int unsigned CLEAR_N = (CLK_MHZ * CLEAR_US > 0) ? CLK_MHZ * CLEAR_US : 1;

    // Terminal counts: a timed state lasts exactly N cycles.
    localparam logic [DW-1:0] PWR_L   = DW'(PWR_N - 1);
    localparam logic [DW-1:0] WAKE_L  = DW'(WAKE_N - 1);
    localparam logic [DW-1:0] PULSE_L = DW'(PULSE_N - 1);
    localparam logic [DW-1:0] CMD_L   = DW'(CMD_N - 1);
    localparam logic [DW-1:0] CLEAR_L = DW'(CLEAR_N - 1);

    localparam logic [1:0] ROW_MAX  = 2'(ROWS - 1);
    localparam logic [5:0] COL_MAX  = 6'(COLS - 1);
    localparam logic [6:0] COLS7    = 7'(COLS);
    localparam logic [7:0] FUNC_SET = (ROWS == 1) ? 8'h20 : 8'h28;

    typedef enum logic [2:0] {
        PWR_WAIT,
        NIB_SETUP,
        NIB_HIGH,
        NIB_SETTLE,
        IDLE
    } state_t;

    typedef enum logic [1:0] {
        SET_CMD,
        SET_WAKE,
        SET_CLEAR
    } settle_t;

    state_t        state_q, state_d;
    settle_t       sel_q, sel_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          en_q, en_d;
    logic          rs_q, rs_d;
    logic [3:0]    nib_q, nib_d;
    logic [7:0]    byte_q, byte_d;
    logic          hi_q, hi_d;
    logic [2:0]    init_q, init_d;
    logic          post_q, post_d;
    logic [7:0]    pend_q, pend_d;
    logic          ready_q, ready_d;
    logic [1:0]    row_q, row_d;
    logic [5:0]    col_q, col_d;

    logic [DW-1:0] settle_max;
    logic [2:0]    step;
    logic          it_single, it_wake;
    logic [7:0]    it_byte;
    logic          ld, ld_rs, ld_single, ld_wake;
    logic [7:0]    ld_byte;
    logic [1:0]    row_nx, go_row;
    logic [5:0]    go_col;

    function automatic logic [6:0] row_base(input logic [1:0] r);
        case (r)
            2'd0:    return 7'h00;
            2'd1:    return 7'h40;
            2'd2:    return COLS7;
            default: return 7'h40 + COLS7;
        endcase
    endfunction

    always_comb begin
        case (sel_q)
            SET_WAKE:  settle_max = WAKE_L;
            SET_CLEAR: settle_max = CLEAR_L;
            default:   settle_max = CMD_L;
        endcase
    end

    // init_q names the init item currently on the bus; step is the one to load next.
    always_comb begin
        step      = (state_q == PWR_WAIT) ? init_q : init_q + 3'd1;
        it_single = 1'b0;
        it_wake   = 1'b0;
        it_byte   = 8'h00;
        case (step)
            3'd0, 3'd1, 3'd2: begin it_single = 1'b1; it_wake = 1'b1; it_byte = 8'h03; end
            3'd3:    begin it_single = 1'b1; it_byte = 8'h02; end
            3'd4:    it_byte = FUNC_SET;
            3'd5:    it_byte = 8'h0C;
            3'd6:    it_byte = 8'h06;
            default: it_byte = 8'h01;
        endcase
    end

    always_comb begin
        row_nx = (row_q == ROW_MAX) ? 2'd0 : row_q + 2'd1;
        go_row = (cmd_data[7:6] > ROW_MAX) ? ROW_MAX : cmd_data[7:6];
        go_col = (cmd_data[5:0] > COL_MAX) ? COL_MAX : cmd_data[5:0];
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q + 1'b1;
        en_d      = en_q;
        rs_d      = rs_q;
        nib_d     = nib_q;
        byte_d    = byte_q;
        hi_d      = hi_q;
        init_d    = init_q;
        post_d    = post_q;
        pend_d    = pend_q;
        ready_d   = ready_q;
        row_d     = row_q;
        col_d     = col_q;
        ld        = 1'b0;
        ld_rs     = 1'b0;
        ld_single = 1'b0;
        ld_wake   = 1'b0;
        ld_byte   = 8'h00;

        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == PWR_L) begin
                    ld        = 1'b1;
                    ld_single = it_single;
                    ld_wake   = it_wake;
                    ld_byte   = it_byte;
                end
            end
            NIB_SETUP: begin
                cnt_d   = '0;
                en_d    = 1'b1;
                state_d = NIB_HIGH;
            end
            NIB_HIGH: begin
                if (cnt_q == PULSE_L) begin
                    cnt_d   = '0;
                    en_d    = 1'b0;
                    state_d = NIB_SETTLE;
                end
            end
            NIB_SETTLE: begin
                if (cnt_q == settle_max) begin
                    if (hi_q) begin
                        // Long settle applies to the clear/home instructions, not to data bytes.
                        cnt_d   = '0;
                        nib_d   = byte_q[3:0];
                        hi_d    = 1'b0;
                        sel_d   = (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02)) ? SET_CLEAR : SET_CMD;
                        state_d = NIB_SETUP;
                    end else if (init_q != 3'd7) begin
                        init_d    = step;
                        ld        = 1'b1;
                        ld_single = it_single;
                        ld_wake   = it_wake;
                        ld_byte   = it_byte;
                    end else if (post_q) begin
                        post_d  = 1'b0;
                        ld      = 1'b1;
                        ld_byte = pend_q;
                    end else begin
                        cnt_d   = '0;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (cmd_valid && ready_q) begin
                    ready_d = 1'b0;
                    ld      = 1'b1;
                    case (cmd_op)
                        2'd0: begin
                            ld_rs   = 1'b1;
                            ld_byte = cmd_data;
                            if (col_q == COL_MAX) begin
                                col_d  = '0;
                                row_d  = row_nx;
                                post_d = 1'b1;
                                pend_d = {1'b1, row_base(row_nx)};
                            end else begin
                                col_d = col_q + 6'd1;
                            end
                        end
                        2'd1: begin
                            ld_byte = 8'h02;
                            row_d   = '0;
                            col_d   = '0;
                        end
                        2'd2: begin
                            ld_byte = 8'h01;
                            row_d   = '0;
                            col_d   = '0;
                        end
                        default: begin
                            ld_byte = {1'b1, row_base(go_row) + {1'b0, go_col}};
                            row_d   = go_row;
                            col_d   = go_col;
                        end
                    endcase
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = PWR_WAIT;
            end
        endcase

        if (ld) begin
            state_d = NIB_SETUP;
            cnt_d   = '0;
            rs_d    = ld_rs;
            if (ld_single) begin
                nib_d = ld_byte[3:0];
                hi_d  = 1'b0;
                sel_d = ld_wake ? SET_WAKE : SET_CMD;
            end else begin
                byte_d = ld_byte;
                nib_d  = ld_byte[7:4];
                hi_d   = 1'b1;
                sel_d  = SET_CMD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PWR_WAIT;
            sel_q   <= SET_CMD;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            nib_q   <= '0;
            byte_q  <= '0;
            hi_q    <= 1'b0;
            init_q  <= '0;
            post_q  <= 1'b0;
            pend_q  <= '0;
            ready_q <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            nib_q   <= nib_d;
            byte_q  <= byte_d;
            hi_q    <= hi_d;
            init_q  <= init_d;
            post_q  <= post_d;
            pend_q  <= pend_d;
            ready_q <= ready_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign cmd_ready  = ready_q;
    assign cur_row    = row_q;
    assign cur_col    = col_q;
    assign db4        = nib_q[0];
    assign db5        = nib_q[1];
    assign db6        = nib_q[2];
    assign db7        = nib_q[3];
    assign rs         = rs_q;
    assign enable     = en_q;
    assign rw         = 1'b0;
    assign lcd_power  = 1'b1;
    assign lcd_bckgnd = 1'b1;

endmodule
